// File: rtl/wb_ahb_pkg.sv
// Shared definitions for the Wishbone-to-AHB initiator: one-hot FSM states and AHB encodings.
package wb_ahb_pkg;

    // One-hot state encoding; anything else decodes to StErr.
    typedef enum logic [5:0] {
        StIdle  = 6'b00_0001,
        StAddr  = 6'b00_0010,
        StData  = 6'b00_0100,
        StResp2 = 6'b00_1000,
        StDone  = 6'b01_0000,
        StErr   = 6'b10_0000
    } state_e;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;

    localparam logic [1:0] HrespOkay  = 2'b00;
    localparam logic [1:0] HrespError = 2'b01;
    localparam logic [1:0] HrespRetry = 2'b10;
    localparam logic [1:0] HrespSplit = 2'b11;

    localparam logic [2:0] HsizeByte = 3'b000;
    localparam logic [2:0] HsizeHalf = 3'b001;
    localparam logic [2:0] HsizeWord = 3'b010;

    localparam logic [2:0] HburstSingle = 3'b000;

    // RETRY and SPLIT are handled identically: the transfer is re-issued.
    function automatic logic hresp_is_retry(logic [1:0] resp);
        return (resp == HrespRetry) || (resp == HrespSplit);
    endfunction

endpackage

// File: rtl/wb_ahb_sel_decode.sv
// Maps a Wishbone byte-lane select onto an AHB transfer size and low address bits.
module wb_ahb_sel_decode
    import wb_ahb_pkg::*;
(
    input  logic [3:0] sel_i,
    output logic [2:0] hsize_o,
    output logic [1:0] addr_lo_o,
    output logic       legal_o
);

    // Only naturally aligned byte, halfword and word patterns are legal.
    always_comb begin
        hsize_o   = HsizeByte;
        addr_lo_o = 2'b00;
        legal_o   = 1'b0;
        unique case (sel_i)
            4'b1111: begin hsize_o = HsizeWord; addr_lo_o = 2'b00; legal_o = 1'b1; end
            4'b0011: begin hsize_o = HsizeHalf; addr_lo_o = 2'b00; legal_o = 1'b1; end
            4'b1100: begin hsize_o = HsizeHalf; addr_lo_o = 2'b10; legal_o = 1'b1; end
            4'b0001: begin hsize_o = HsizeByte; addr_lo_o = 2'b00; legal_o = 1'b1; end
            4'b0010: begin hsize_o = HsizeByte; addr_lo_o = 2'b01; legal_o = 1'b1; end
            4'b0100: begin hsize_o = HsizeByte; addr_lo_o = 2'b10; legal_o = 1'b1; end
            4'b1000: begin hsize_o = HsizeByte; addr_lo_o = 2'b11; legal_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_ahb_master_fsm.sv
// Initiator-side AHB FSM: turns one Wishbone classic cycle into one AHB SINGLE transfer,
// handling wait states, two-cycle ERROR/RETRY/SPLIT responses and a bounded retry count.
module wb_ahb_master_fsm
    import wb_ahb_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned RETRY_MAX = 15
) (
    input  logic          ahb_hclk,
    input  logic          ahb_hreset,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [AW-1:0] ahb_haddr,
    output logic [1:0]    ahb_htrans,
    output logic          ahb_hwrite,
    output logic [2:0]    ahb_hsize,
    output logic [2:0]    ahb_hburst,
    output logic [DW-1:0] ahb_hwdata,
    input  logic [DW-1:0] ahb_hrdata,
    input  logic          ahb_hready,
    input  logic [1:0]    ahb_hresp,
    output logic          fsm_error
);

    localparam int unsigned RcW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RcW-1:0] RetryMax = RcW'(RETRY_MAX);

    state_e         state_q, state_d;
    logic [RcW-1:0] retry_cnt_q, retry_cnt_d;
    logic [AW-1:0]  haddr_q;
    logic [1:0]     htrans_q, htrans_d;
    logic           hwrite_q;
    logic [2:0]     hsize_q;
    logic [DW-1:0]  hwdata_q;
    logic [DW-1:0]  rdata_q;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic           fsm_error_q, fsm_error_d;
    logic           cmd_capture;
    logic           rdata_latch;

    logic [2:0]     dec_hsize;
    logic [1:0]     dec_addr_lo;
    logic           dec_legal;
    logic           unused_adr;

    // The byte offset comes from the lane decode, not from the Wishbone address.
    assign unused_adr = ^wb_adr_i[1:0];

    wb_ahb_sel_decode u_sel_decode (
        .sel_i     (wb_sel_i),
        .hsize_o   (dec_hsize),
        .addr_lo_o (dec_addr_lo),
        .legal_o   (dec_legal)
    );

    // Next-state, command capture and completion decisions.
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        cmd_capture = 1'b0;
        rdata_latch = 1'b0;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wb_cyc_i && wb_stb_i) begin
                    if (dec_legal) begin
                        state_d     = StAddr;
                        retry_cnt_d = '0;
                        cmd_capture = 1'b1;
                    end else begin
                        // Illegal lanes never reach the bus.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StAddr: begin
                if (ahb_hready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (ahb_hready) begin
                    state_d = StDone;
                    if (ahb_hresp == HrespOkay) begin
                        ack_d       = wb_cyc_i;
                        rdata_latch = ~hwrite_q;
                    end else begin
                        // Single-cycle non-OKAY is a slave protocol violation; report it.
                        err_d = wb_cyc_i;
                    end
                end else if (ahb_hresp != HrespOkay) begin
                    state_d = StResp2;
                end
            end
            StResp2: begin
                if (ahb_hready) begin
                    if (hresp_is_retry(ahb_hresp) && (retry_cnt_q < RetryMax)) begin
                        retry_cnt_d = retry_cnt_q + RcW'(1);
                        state_d     = StAddr;
                    end else begin
                        state_d = StDone;
                        err_d   = wb_cyc_i;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StErr;
        endcase
        htrans_d    = (state_d == StAddr) ? HtransNonseq : HtransIdle;
        fsm_error_d = (state_d == StErr);
    end

    // State, retry count and all bus-facing outputs are registered.
    always_ff @(posedge ahb_hclk or posedge ahb_hreset) begin
        if (ahb_hreset) begin
            state_q     <= StIdle;
            retry_cnt_q <= '0;
            haddr_q     <= '0;
            htrans_q    <= HtransIdle;
            hwrite_q    <= 1'b0;
            hsize_q     <= HsizeByte;
            hwdata_q    <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            fsm_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            htrans_q    <= htrans_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            fsm_error_q <= fsm_error_d;
            if (cmd_capture) begin
                haddr_q  <= {wb_adr_i[AW-1:2], dec_addr_lo};
                hwrite_q <= wb_we_i;
                hsize_q  <= dec_hsize;
                hwdata_q <= wb_dat_i;
            end
            if (rdata_latch) begin
                rdata_q <= ahb_hrdata;
            end
        end
    end

    assign wb_dat_o   = rdata_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign ahb_haddr  = haddr_q;
    assign ahb_htrans = htrans_q;
    assign ahb_hwrite = hwrite_q;
    assign ahb_hsize  = hsize_q;
    assign ahb_hburst = HburstSingle;
    assign ahb_hwdata = hwdata_q;
    assign fsm_error  = fsm_error_q;

endmodule

// File: tb/tb_wb_ahb_master_fsm.sv
// Scoreboard bench for wb_ahb_master_fsm: a scripted AHB slave, a transaction-level model
// that predicts outcome/latency/attempt count, and a monitor that checks each completion.
module tb_wb_ahb_master_fsm;

    localparam int RetryMax = 15;

    logic        ahb_hclk = 1'b0;
    logic        ahb_hreset = 1'b0;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] ahb_haddr;
    logic [1:0]  ahb_htrans;
    logic        ahb_hwrite;
    logic [2:0]  ahb_hsize, ahb_hburst;
    logic [31:0] ahb_hwdata;
    logic [31:0] ahb_hrdata = '0;
    logic        ahb_hready = 1'b1;
    logic [1:0]  ahb_hresp = 2'b00;
    logic        fsm_error;

    wb_ahb_master_fsm dut (
        .ahb_hclk   (ahb_hclk),
        .ahb_hreset (ahb_hreset),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .ahb_haddr  (ahb_haddr),
        .ahb_htrans (ahb_htrans),
        .ahb_hwrite (ahb_hwrite),
        .ahb_hsize  (ahb_hsize),
        .ahb_hburst (ahb_hburst),
        .ahb_hwdata (ahb_hwdata),
        .ahb_hrdata (ahb_hrdata),
        .ahb_hready (ahb_hready),
        .ahb_hresp  (ahb_hresp),
        .fsm_error  (fsm_error)
    );

    always #5 ahb_hclk = ~ahb_hclk;

    int unsigned cyc_cnt = 0;
    always @(posedge ahb_hclk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int         aw;
        int         dw;
        logic [1:0] resp;
    } att_t;

    typedef struct {
        logic        is_err;
        logic        illegal;
        logic        chk_data;
        logic [31:0] rdata;
        int unsigned lat;
        int unsigned attempts;
        int unsigned issue;
    } exp_t;

    att_t att_q[$];
    exp_t exp_q[$];

    logic [31:0] cur_haddr, cur_wdata, cur_rdata;
    logic [2:0]  cur_hsize;
    logic        cur_we;

    int n_checks = 0;
    int n_fail = 0;
    int nonseq_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scripted AHB slave: each NONSEQ consumes one attempt (addr waits, data waits, response).
    typedef enum {PIdle, PAddr, PData, PResp2} sphase_e;
    sphase_e sph = PIdle;
    att_t    cur_att;
    int      scnt;

    initial begin
        forever begin
            @(posedge ahb_hclk);
            #1;
            if (ahb_hreset) begin
                sph        = PIdle;
                ahb_hready = 1'b1;
                ahb_hresp  = 2'b00;
            end else begin
                if (sph == PIdle) begin
                    ahb_hready = 1'b1;
                    ahb_hresp  = 2'b00;
                    if (ahb_htrans == 2'b10) begin
                        check("nonseq_expected", 32'(att_q.size() != 0), 32'd1);
                        if (att_q.size() != 0) cur_att = att_q.pop_front();
                        else cur_att = '{aw: 0, dw: 0, resp: 2'b00};
                        check("haddr", ahb_haddr, cur_haddr);
                        check("hsize", 32'(ahb_hsize), 32'(cur_hsize));
                        check("hwrite", 32'(ahb_hwrite), 32'(cur_we));
                        check("hburst", 32'(ahb_hburst), 32'd0);
                        scnt = cur_att.aw;
                        sph  = PAddr;
                    end
                end
                if (sph == PAddr) begin
                    if (scnt > 0) begin
                        ahb_hready = 1'b0;
                        scnt--;
                    end else begin
                        ahb_hready = 1'b1;
                        sph        = PData;
                        scnt       = cur_att.dw;
                    end
                end else if (sph == PData) begin
                    check("htrans_in_data", 32'(ahb_htrans), 32'd0);
                    if (cur_we) check("hwdata", ahb_hwdata, cur_wdata);
                    if (scnt > 0) begin
                        ahb_hready = 1'b0;
                        ahb_hresp  = 2'b00;
                        scnt--;
                    end else if (cur_att.resp == 2'b00) begin
                        ahb_hready = 1'b1;
                        ahb_hresp  = 2'b00;
                        ahb_hrdata = cur_rdata;
                        sph        = PIdle;
                    end else begin
                        ahb_hready = 1'b0;
                        ahb_hresp  = cur_att.resp;
                        sph        = PResp2;
                    end
                end else if (sph == PResp2) begin
                    ahb_hready = 1'b1;
                    ahb_hresp  = cur_att.resp;
                    sph        = PIdle;
                end
            end
        end
    end

    // Monitor: counts issued transfers and checks every ack/err against the scoreboard.
    initial begin
        logic prev_ns;
        exp_t e;
        int unsigned lat;
        prev_ns = 1'b0;
        forever begin
            @(posedge ahb_hclk);
            #1;
            if (ahb_hreset) begin
                nonseq_cnt = 0;
                prev_ns    = 1'b0;
            end else begin
                if (ahb_htrans == 2'b10 && !prev_ns) nonseq_cnt++;
                prev_ns = (ahb_htrans == 2'b10);
                if (fsm_error) check("fsm_error", 32'(fsm_error), 32'd0);
                if (wb_ack_o || wb_err_o) begin
                    check("response_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e   = exp_q.pop_front();
                        lat = cyc_cnt - e.issue;
                        check("err", 32'(wb_err_o), 32'(e.is_err));
                        check("ack", 32'(wb_ack_o), 32'(!e.is_err));
                        if (e.illegal) check("illegal_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
                        else check("latency", lat, e.lat);
                        check("nonseq_count", 32'(nonseq_cnt), e.attempts);
                        if (e.chk_data) check("wb_dat_o", wb_dat_o, e.rdata);
                    end
                    nonseq_cnt = 0;
                end
            end
        end
    end

    // Builds the slave script, predicts the outcome, issues the request, waits for completion.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, input logic [31:0] rdat, input int aw,
                           input int dw, input int n_retry, input logic [1:0] fin);
        exp_t e;
        att_t a;
        int   pc, lo, retries;
        logic legal, done, got;
        pc    = $countones(sel);
        legal = (sel == 4'b1111) || (sel == 4'b0011) || (sel == 4'b1100) || (pc == 1);
        lo    = 0;
        for (int i = 3; i >= 0; i--) if (sel[i]) lo = i;
        att_q.delete();
        a.aw = aw;
        a.dw = dw;
        for (int i = 0; i < n_retry; i++) begin
            a.resp = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
            att_q.push_back(a);
        end
        a.resp = fin;
        att_q.push_back(a);
        e.illegal  = !legal;
        e.rdata    = rdat;
        e.is_err   = 1'b1;
        e.attempts = 0;
        e.lat      = 1;
        if (!legal) begin
            att_q.delete();
        end else begin
            retries = 0;
            done    = 1'b0;
            foreach (att_q[i]) begin
                if (!done) begin
                    e.attempts++;
                    e.lat += 1 + att_q[i].aw;
                    if (att_q[i].resp == 2'b00) begin
                        e.lat   += 1 + att_q[i].dw;
                        e.is_err = 1'b0;
                        done     = 1'b1;
                    end else begin
                        e.lat += 2 + att_q[i].dw;
                        if (att_q[i].resp == 2'b01 || retries >= RetryMax) done = 1'b1;
                        else retries++;
                    end
                end
            end
        end
        e.chk_data = legal && !we && !e.is_err;
        cur_haddr  = {adr[31:2], 2'(lo)};
        cur_hsize  = (pc == 4) ? 3'd2 : (pc == 2) ? 3'd1 : 3'd0;
        cur_we     = we;
        cur_wdata  = wdat;
        cur_rdata  = rdat;
        wb_cyc_i   = 1'b1;
        wb_stb_i   = 1'b1;
        wb_we_i    = we;
        wb_adr_i   = adr;
        wb_dat_i   = wdat;
        wb_sel_i   = sel;
        e.issue    = cyc_cnt;
        exp_q.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(posedge ahb_hclk);
            #1;
            got = wb_ack_o || wb_err_o;
        end
        check("completion_in_budget", 32'(got), 32'd1);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        att_q.delete();
        @(posedge ahb_hclk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_htrans"}, 32'(ahb_htrans), 32'd0);
        check({tag, "_haddr"}, ahb_haddr, 32'd0);
        check({tag, "_hwrite"}, 32'(ahb_hwrite), 32'd0);
        check({tag, "_hsize"}, 32'(ahb_hsize), 32'd0);
        check({tag, "_hwdata"}, ahb_hwdata, 32'd0);
        check({tag, "_wb_dat_o"}, wb_dat_o, 32'd0);
        check({tag, "_ack"}, 32'(wb_ack_o), 32'd0);
        check({tag, "_err"}, 32'(wb_err_o), 32'd0);
        check({tag, "_fsm_error"}, 32'(fsm_error), 32'd0);
    endtask

    logic [3:0] legal_sels[7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        logic got;
        #1 ahb_hreset = 1'b1;
        #1 check_reset_values("reset");
        repeat (2) @(posedge ahb_hclk);
        #3 ahb_hreset = 1'b0;
        @(posedge ahb_hclk);
        #1;

        run_txn(1'b0, 32'h1000, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0, 0, 2'b00);
        run_txn(1'b1, 32'h2000, 4'b0100, 32'h00AA0000, 32'h0, 0, 2, 0, 2'b00);
        run_txn(1'b0, 32'h3004, 4'b1111, 32'h0, 32'h12345678, 0, 0, 0, 2'b01);
        run_txn(1'b0, 32'h4008, 4'b0011, 32'h0, 32'hCAFE5A5A, 0, 0, 2, 2'b00);
        run_txn(1'b1, 32'h5000, 4'b1100, 32'hBEEF0000, 32'h0, 1, 1, 15, 2'b00);
        run_txn(1'b0, 32'h6000, 4'b1111, 32'h0, 32'h0BADF00D, 0, 0, 16, 2'b00);
        run_txn(1'b1, 32'h7000, 4'b0101, 32'h11223344, 32'h0, 0, 0, 0, 2'b00);
        run_txn(1'b0, 32'h7100, 4'b0000, 32'h0, 32'h0, 0, 0, 0, 2'b00);
        run_txn(1'b0, 32'h8001, 4'b1000, 32'h0, 32'h77000000, 2, 0, 0, 2'b00);

        // Dropped cycle: transfer finishes on AHB but no ack reaches Wishbone.
        att_q.push_back('{aw: 0, dw: 4, resp: 2'b00});
        cur_haddr = 32'h9000; cur_hsize = 3'd2; cur_we = 1'b0; cur_rdata = 32'h55AA55AA;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h9000; wb_sel_i = 4'hF;
        @(posedge ahb_hclk);
        #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (10) @(posedge ahb_hclk);
        #1;
        check("drop_nonseq_count", 32'(nonseq_cnt), 32'd1);
        check("drop_htrans_idle", 32'(ahb_htrans), 32'd0);
        nonseq_cnt = 0;
        att_q.delete();

        // Read whose wb_dat_o is non-zero before reset, then reset during its data phase.
        run_txn(1'b0, 32'hA000, 4'b1111, 32'h0, 32'hFEEDFACE, 0, 0, 0, 2'b00);
        att_q.push_back('{aw: 0, dw: 20, resp: 2'b00});
        cur_haddr = 32'hB000; cur_hsize = 3'd2; cur_we = 1'b1; cur_wdata = 32'h13572468;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'hB000;
        wb_dat_i = 32'h13572468; wb_sel_i = 4'hF;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge ahb_hclk);
            #1;
            got = (sph == PData);
        end
        check("reached_data_phase", 32'(got), 32'd1);
        #2 ahb_hreset = 1'b1;
        #1 check_reset_values("midreset");
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (2) @(posedge ahb_hclk);
        #3 ahb_hreset = 1'b0;
        att_q.delete();
        @(posedge ahb_hclk);
        #1;
        run_txn(1'b0, 32'hC000, 4'b1111, 32'h0, 32'h600DCAFE, 0, 0, 0, 2'b00);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] sel;
            int         nr;
            sel = ($urandom_range(0, 9) < 8) ? legal_sels[$urandom_range(0, 6)]
                                             : 4'($urandom_range(0, 15));
            nr  = ($urandom_range(0, 19) == 0) ? 16 : int'($urandom_range(0, 2));
            run_txn(1'($urandom_range(0, 1)), $urandom, sel, $urandom, $urandom,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), nr,
                    ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00);
        end

        repeat (3) @(posedge ahb_hclk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
